soc_pd_seq_ctrl: RTL and testbench

Parametrised per-domain power sequencer for the SoC power-management path. It takes on, off and retention requests from the PMU. For each domain it drives the power switch, isolation, retention-save and domain reset in the correct order. It waits on a synchronised power-good signal with a timeout, and it detects and reports sequencing faults. Domains selected by AON_MASK are always on.

---
 rtl/soc_pd_seq_ctrl_if.sv | 37 +++
 rtl/soc_pd_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_soc_pd_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_pd_seq_ctrl_if.sv
`default_nettype none
// ==== soc_pd_seq_ctrl_if : PMU <-> per-domain power sequencer request/status bundle
// ==== Rev 1.0
interface soc_pd_seq_ctrl_if #(
  parameter int NUM_PD = 12
);
  logic [NUM_PD-1:0]   on_req;
  logic [NUM_PD-1:0]   off_req;
  logic [NUM_PD-1:0]   ret_req;
  logic [NUM_PD-1:0]   err_clr;
  logic [NUM_PD-1:0]   pg_in;
  logic [NUM_PD-1:0]   sw_en;
  logic [NUM_PD-1:0]   iso_en;
  logic [NUM_PD-1:0]   ret_en;
  logic [NUM_PD-1:0]   pd_rst_n;
  logic [NUM_PD-1:0]   on_ack;
  logic [NUM_PD-1:0]   off_ack;
  logic [NUM_PD-1:0]   ret_ack;
  logic [4*NUM_PD-1:0] pd_state;
  logic [2*NUM_PD-1:0] err_code;
  logic                busy;
  logic                all_on;
  logic                err_irq;

  modport master (
    output on_req, off_req, ret_req, err_clr, pg_in,
    input  sw_en, iso_en, ret_en, pd_rst_n, on_ack, off_ack, ret_ack,
    input  pd_state, err_code, busy, all_on, err_irq
  );

  modport slave (
    input  on_req, off_req, ret_req, err_clr, pg_in,
    output sw_en, iso_en, ret_en, pd_rst_n, on_ack, off_ack, ret_ack,
    output pd_state, err_code, busy, all_on, err_irq
  );
endinterface
`default_nettype wire

// File: rtl/soc_pd_seq_ctrl.sv
`default_nettype none
// ==== soc_pd_seq_ctrl : per-domain power sequencer (switch/iso/retention/reset ordering, pg timeout, faults)
// ==== Rev 1.0
module soc_pd_seq_ctrl #(
  parameter int                NUM_PD     = 12,
  parameter logic [NUM_PD-1:0] AON_MASK   = 12'h001,
  parameter int                TMR_W      = 8,
  parameter int                ON_DLY     = 8,
  parameter int                OFF_DLY    = 8,
  parameter int                PG_TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  soc_pd_seq_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_OFF      = 4'd0,
    S_PWR_UP   = 4'd1,
    S_RST_WAIT = 4'd2,
    S_ON       = 4'd3,
    S_ISO_DN   = 4'd4,
    S_PWR_DN   = 4'd5,
    S_RET      = 4'd6,
    S_ERR      = 4'd15
  } state_t;

  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_DLY - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_DLY - 1);
  localparam logic [TMR_W-1:0] PG_LAST  = TMR_W'(PG_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = {TMR_W{1'b1}};
  localparam logic [7:0]       OUT_RST  = 8'b0010_0010;

  // Output bundle: {busy, ret_ack, off_ack, on_ack, rst_n, ret, iso, sw}
  function automatic logic [7:0] decode(state_t s, logic rflag, logic tgt);
    case (s)
      S_OFF:      decode = 8'b0010_0010;
      S_PWR_UP:   decode = {4'b1000, rflag, rflag, 2'b11};
      S_RST_WAIT: decode = 8'b1000_0011;
      S_ON:       decode = 8'b0001_1001;
      S_ISO_DN:   decode = {4'b1000, 1'b1, tgt, 2'b11};
      S_PWR_DN:   decode = 8'b1000_0010;
      S_RET:      decode = 8'b0100_1110;
      default:    decode = 8'b0000_0010;
    endcase
  endfunction

  logic [NUM_PD-1:0] busy_v;

  for (genvar i = 0; i < NUM_PD; i++) begin : g_pd
    if (AON_MASK[i]) begin : g_aon
      assign bus.sw_en[i]           = 1'b1;
      assign bus.iso_en[i]          = 1'b0;
      assign bus.ret_en[i]          = 1'b0;
      assign bus.pd_rst_n[i]        = 1'b1;
      assign bus.on_ack[i]          = 1'b1;
      assign bus.off_ack[i]         = 1'b0;
      assign bus.ret_ack[i]         = 1'b0;
      assign bus.pd_state[4*i +: 4] = S_ON;
      assign bus.err_code[2*i +: 2] = 2'b00;
      assign busy_v[i]              = 1'b0;
    end else begin : g_seq
      logic [1:0]       pg_sync;
      logic             pg_s;
      state_t           state, nxt;
      logic [TMR_W-1:0] timer;
      logic             rflag, nrflag, tgt, ntgt;
      logic [1:0]       err, nerr;
      logic [7:0]       outs;

      assign pg_s = pg_sync[1];

      always_comb begin
        nxt    = state;
        nrflag = rflag;
        ntgt   = tgt;
        nerr   = err;
        if (bus.err_clr[i]) nerr = 2'b00;
        case (state)
          S_OFF: begin
            if ((bus.on_req[i] & bus.off_req[i]) | bus.ret_req[i]) begin
              nerr = 2'b11;
            end else if (bus.on_req[i]) begin
              nxt    = S_PWR_UP;
              nrflag = 1'b0;
            end
          end
          S_PWR_UP: begin
            // A retention wake-up skips RST_WAIT: the domain's state was never reset.
            if (pg_s) begin
              nxt    = rflag ? S_ON : S_RST_WAIT;
              nrflag = 1'b0;
            end else if (timer == PG_LAST) begin
              nxt  = S_ERR;
              nerr = 2'b01;
            end
          end
          S_RST_WAIT: if (timer == ON_LAST) nxt = S_ON;
          S_ON: begin
            if (!pg_s) begin
              nxt  = S_ERR;
              nerr = 2'b10;
            end else if (bus.off_req[i]) begin
              nxt  = S_ISO_DN;
              ntgt = 1'b0;
            end else if (bus.ret_req[i]) begin
              nxt  = S_ISO_DN;
              ntgt = 1'b1;
            end
          end
          S_ISO_DN: nxt = tgt ? S_RET : S_PWR_DN;
          S_PWR_DN: if (timer == OFF_LAST) nxt = S_OFF;
          S_RET: begin
            if (bus.off_req[i]) begin
              nxt = S_PWR_DN;
            end else if (!bus.ret_req[i]) begin
              nxt    = S_PWR_UP;
              nrflag = 1'b1;
            end
          end
          S_ERR: if (bus.err_clr[i]) nxt = S_OFF;
          default: begin
            nxt  = S_ERR;
            nerr = 2'b11;
          end
        endcase
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          pg_sync <= 2'b00;
          state   <= S_OFF;
          timer   <= '0;
          rflag   <= 1'b0;
          tgt     <= 1'b0;
          err     <= 2'b00;
          outs    <= OUT_RST;
        end else begin
          pg_sync <= {pg_sync[0], bus.pg_in[i]};
          state   <= nxt;
          rflag   <= nrflag;
          tgt     <= ntgt;
          err     <= nerr;
          outs    <= decode(nxt, nrflag, ntgt);
          if (nxt != state)        timer <= '0;
          else if (timer != TMR_MAX) timer <= timer + 1'b1;
        end
      end

      assign bus.sw_en[i]           = outs[0];
      assign bus.iso_en[i]          = outs[1];
      assign bus.ret_en[i]          = outs[2];
      assign bus.pd_rst_n[i]        = outs[3];
      assign bus.on_ack[i]          = outs[4];
      assign bus.off_ack[i]         = outs[5];
      assign bus.ret_ack[i]         = outs[6];
      assign busy_v[i]              = outs[7];
      assign bus.pd_state[4*i +: 4] = state;
      assign bus.err_code[2*i +: 2] = err;
    end
  end

  assign bus.busy    = |busy_v;
  assign bus.all_on  = &bus.on_ack;
  assign bus.err_irq = |bus.err_code;

endmodule
`default_nettype wire

// File: tb/tb_soc_pd_seq_ctrl.sv
`default_nettype none
// ==== tb_soc_pd_seq_ctrl : directed vector bench for soc_pd_seq_ctrl (4 domains, domain 0 always-on)
// ==== Rev 1.0
module tb_soc_pd_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  soc_pd_seq_ctrl_if #(.NUM_PD(4)) bus ();

  soc_pd_seq_ctrl #(
    .NUM_PD     (4),
    .AON_MASK   (4'b0001),
    .TMR_W      (8),
    .ON_DLY     (4),
    .OFF_DLY    (3),
    .PG_TIMEOUT (20)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  on;
    logic [3:0]  off;
    logic [3:0]  ret;
    logic [3:0]  clr;
    logic [15:0] st;
    logic [7:0]  err;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    bus.on_req  = '0;
    bus.off_req = '0;
    bus.ret_req = '0;
    bus.err_clr = '0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_state"},   bus.pd_state, 32'h0003);
    chk({tag, "_sw"},      bus.sw_en,    32'h1);
    chk({tag, "_iso"},     bus.iso_en,   32'hE);
    chk({tag, "_ret"},     bus.ret_en,   32'h0);
    chk({tag, "_rstn"},    bus.pd_rst_n, 32'h1);
    chk({tag, "_onack"},   bus.on_ack,   32'h1);
    chk({tag, "_offack"},  bus.off_ack,  32'hE);
    chk({tag, "_retack"},  bus.ret_ack,  32'h0);
    chk({tag, "_err"},     bus.err_code, 32'h0);
    chk({tag, "_busy"},    bus.busy,     32'h0);
    chk({tag, "_all_on"},  bus.all_on,   32'h0);
    chk({tag, "_irq"},     bus.err_irq,  32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ret_st[8]  = '{4, 6, 6, 6, 6, 1, 1, 3};
    int ret_ren[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    int pri_st[5]  = '{4, 5, 5, 5, 0};

    //             on       off      ret      clr      state     err
    vt[0] = '{4'b0011, 4'b0011, 4'b0000, 4'b0000, 16'h0003, 8'h0C};
    vt[1] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 16'h0003, 8'h00};
    vt[2] = '{4'b0000, 4'b0000, 4'b0101, 4'b0000, 16'h0003, 8'h30};
    vt[3] = '{4'b0000, 4'b0001, 4'b0000, 4'b0100, 16'h0003, 8'h00};
    vt[4] = '{4'b0001, 4'b0000, 4'b0000, 4'b0000, 16'h0003, 8'h00};
    vt[5] = '{4'b1001, 4'b1001, 4'b0000, 4'b0000, 16'h0003, 8'hC0};

    rst_n = 1'b0;
    zero_inputs();
    bus.pg_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("rst");
    rst_n = 1'b1;
    tick();

    // Illegal requests in OFF and always-on domain immunity
    for (int k = 0; k < 6; k++) begin
      bus.on_req  = vt[k].on;
      bus.off_req = vt[k].off;
      bus.ret_req = vt[k].ret;
      bus.err_clr = vt[k].clr;
      tick();
      chk($sformatf("vec%0d_state", k), bus.pd_state, vt[k].st);
      chk($sformatf("vec%0d_err", k),   bus.err_code, vt[k].err);
      chk($sformatf("vec%0d_irq", k),   bus.err_irq,  (vt[k].err != 8'h00));
      chk($sformatf("vec%0d_sw", k),    bus.sw_en,    32'h1);
    end
    zero_inputs();
    bus.err_clr[3] = 1'b1;
    tick();
    zero_inputs();
    chk("clr3_err", bus.err_code, 32'h0);

    // Cold power-up of domain 1
    bus.on_req[1] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk($sformatf("pu_state_c%0d", c), bus.pd_state[7:4], (c <= 7) ? 1 : (c <= 11) ? 2 : 3);
      chk($sformatf("pu_busy_c%0d", c),  bus.busy, (c <= 11) ? 1 : 0);
      chk($sformatf("pu_sw_c%0d", c),    bus.sw_en[1], 1);
      if (c == 7) chk("pu_rstn_c7", bus.pd_rst_n[1], 0);
      if (c == 5) bus.pg_in[1] = 1'b1;
    end
    chk("pu_onack",  bus.on_ack[1],   1);
    chk("pu_iso",    bus.iso_en[1],   0);
    chk("pu_rstn",   bus.pd_rst_n[1], 1);
    chk("pu_all_on", bus.all_on,      0);
    bus.on_req[1] = 1'b0;

    // Power-good timeout on domain 2
    bus.on_req[2] = 1'b1;
    tick();
    bus.on_req[2] = 1'b0;
    chk("to_state_c1", bus.pd_state[11:8], 1);
    for (int c = 2; c <= 20; c++) tick();
    chk("to_state_c20", bus.pd_state[11:8], 1);
    tick();
    chk("to_state_c21", bus.pd_state[11:8], 15);
    chk("to_err",       bus.err_code[5:4],  2'b01);
    chk("to_irq",       bus.err_irq,        1);
    chk("to_sw",        bus.sw_en[2],       0);
    chk("to_iso",       bus.iso_en[2],      1);
    bus.on_req[2] = 1'b1;
    tick();
    chk("to_ignore_req", bus.pd_state[11:8], 15);
    bus.on_req[2]  = 1'b0;
    bus.err_clr[2] = 1'b1;
    tick();
    bus.err_clr[2] = 1'b0;
    chk("to_clr_state", bus.pd_state[11:8], 0);
    chk("to_clr_err",   bus.err_code,       32'h0);
    chk("to_clr_irq",   bus.err_irq,        0);
    chk("to_d1_on",     bus.pd_state[7:4],  3);

    // Retention round trip on domain 1
    bus.ret_req[1] = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("ret_state_c%0d", c), bus.pd_state[7:4], ret_st[c-1]);
      chk($sformatf("ret_en_c%0d", c),    bus.ret_en[1],     ret_ren[c-1]);
      if (c == 2) begin
        chk("ret_sw",    bus.sw_en[1],    0);
        chk("ret_rstn",  bus.pd_rst_n[1], 1);
        chk("ret_ack",   bus.ret_ack[1],  1);
        bus.pg_in[1] = 1'b0;
      end
      if (c == 5) begin
        bus.ret_req[1] = 1'b0;
        bus.pg_in[1]   = 1'b1;
      end
      if (c == 6) begin
        chk("ret_wake_rstn", bus.pd_rst_n[1], 1);
        chk("ret_wake_sw",   bus.sw_en[1],    1);
      end
    end

    // off_req beats ret_req in ON
    bus.off_req[1] = 1'b1;
    bus.ret_req[1] = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk($sformatf("pri_state_c%0d", c),  bus.pd_state[7:4], pri_st[c-1]);
      chk($sformatf("pri_offack_c%0d", c), bus.off_ack[1],    (c == 5) ? 1 : 0);
      chk($sformatf("pri_ret_c%0d", c),    bus.ret_en[1],     0);
      chk($sformatf("pri_busy_c%0d", c),   bus.busy,          (c <= 4) ? 1 : 0);
      if (c == 1) begin
        bus.off_req[1] = 1'b0;
        bus.ret_req[1] = 1'b0;
      end
    end
    bus.pg_in[1] = 1'b0;

    // Power-good lost on domain 3
    bus.on_req[3] = 1'b1;
    bus.pg_in[3]  = 1'b1;
    n = 0;
    while (bus.pd_state[15:12] != 4'd3 && n < 20) begin
      tick();
      n++;
    end
    bus.on_req[3] = 1'b0;
    chk("pgl_reach_on", bus.pd_state[15:12], 3);
    chk("pgl_up_cycles", n, 7);
    bus.pg_in[3] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      chk($sformatf("pgl_state_c%0d", c), bus.pd_state[15:12], (c < 3) ? 3 : 15);
    end
    chk("pgl_err",  bus.err_code[7:6], 2'b10);
    chk("pgl_iso",  bus.iso_en[3],     1);
    chk("pgl_rstn", bus.pd_rst_n[3],   0);
    chk("pgl_irq",  bus.err_irq,       1);

    // Asynchronous reset in the middle of a power-up
    bus.on_req[2] = 1'b1;
    tick();
    tick();
    chk("mid_pwr_up", bus.pd_state[11:8], 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("async");
    bus.on_req[2] = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_rst_state",  bus.pd_state, 32'h0003);
    chk("post_rst_offack", bus.off_ack,  32'hE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
